// File: rtl/coord_seq_pkg.sv
// coord_seq_pkg: shared definitions for the coordinate sequencer.
//   - state_t: sequencer FSM states
//   - BW_* : bitwidth encodings (lane count selection)
//   - lane_count / lane_active: active-lane helpers used to mask chunk lanes
//   - DEF_* : default values for the block parameters
package coord_seq_pkg;

   localparam int DEF_LANES     = 16;
   localparam int DEF_IDX_W     = 4;
   localparam int DEF_CNT_W     = 8;
   localparam int DEF_COORD_LAT = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] BW_16  = 2'b00;
   localparam logic [1:0] BW_8   = 2'b01;
   localparam logic [1:0] BW_4   = 2'b10;
   localparam logic [1:0] BW_BAD = 2'b11;

   // Number of lanes carrying data for a given bitwidth code.
   function automatic int lane_count(input logic [1:0] bw, input int max_lanes);
      int n;
      case (bw)
         BW_16:   n = max_lanes;
         BW_8:    n = max_lanes / 2;
         BW_4:    n = max_lanes / 4;
         default: n = 0;
      endcase
      return n;
   endfunction

   // True when lane 'lane' carries data for bitwidth code 'bw'.
   function automatic logic lane_active(input logic [1:0] bw, input int lane, input int max_lanes);
      return (lane < lane_count(bw, max_lanes));
   endfunction

endpackage

// File: rtl/coord_sequencer_pipe.sv
// coord_valid_pipe: LAT-deep delay line for the issue strobe.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear of every stage (abort)
//   in_valid     : strobe entering the line (cc_issue)
//   out_valid    : in_valid delayed by exactly LAT cycles (LAT >= 1)
//   empty        : no strobe held in any stage
module coord_valid_pipe
   import coord_seq_pkg::*;
#(
   parameter int LAT = DEF_COORD_LAT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic flush,
   input  logic in_valid,
   output logic out_valid,
   output logic empty
);

   logic [LAT-1:0] line;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line <= '0;
      end else if (flush) begin
         line <= '0;
      end else begin
         line[0] <= in_valid;
         for (int i = 1; i < LAT; i++) begin
            line[i] <= line[i-1];
         end
      end
   end

   assign out_valid = line[LAT-1];
   assign empty     = ~|line;

endmodule

// File: rtl/coord_sequencer.sv
// coord_sequencer: pairs weight/activation index chunks and issues them in
// lockstep to the coordinate unit, grouped into passes (tiles) with a
// one-cycle prefix-state clear before each pass.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, abort                 job start pulse (IDLE only), synchronous abort
//   bitwidth, weight_dim,
//   activation_dim               configuration latched on start
//   chunks_per_tile, num_tiles   job geometry (chunk-pairs per pass, passes)
//   w_valid/w_ready/w_indices    weight chunk stream (lane 0 in LSBs)
//   a_valid/a_ready/a_indices    activation chunk stream
//   cc_*                         registered controls/data to the coordinate unit
//   coord_valid                  cc_issue delayed by COORD_LAT
//   busy, done, cfg_err          status; done/cfg_err are single-cycle pulses
//   dbg_state                    current FSM state
//   stall_cycles, issue_count    only with COORD_SEQ_STALL_COUNT_EN defined:
//                                RUN cycles without transfer, transfers taken
//
// Handshake: a chunk pair transfers only in a cycle where the FSM is in RUN
// and both w_valid and a_valid are high. Each ready is RUN gated by the other
// stream's valid, so neither stream can ever be consumed alone.
module coord_sequencer
   import coord_seq_pkg::*;
#(
   parameter int LANES     = DEF_LANES,
   parameter int IDX_W     = DEF_IDX_W,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int COORD_LAT = DEF_COORD_LAT
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [1:0]             bitwidth,
   input  logic [3:0]             weight_dim,
   input  logic [8:0]             activation_dim,
   input  logic [CNT_W-1:0]       chunks_per_tile,
   input  logic [CNT_W-1:0]       num_tiles,
   input  logic                   w_valid,
   output logic                   w_ready,
   input  logic [LANES*IDX_W-1:0] w_indices,
   input  logic                   a_valid,
   output logic                   a_ready,
   input  logic [LANES*IDX_W-1:0] a_indices,
   output logic                   cc_clear_n,
   output logic [1:0]             cc_bitwidth,
   output logic [3:0]             cc_weight_dim,
   output logic [8:0]             cc_activation_dim,
   output logic [LANES*IDX_W-1:0] cc_weight_indices,
   output logic [LANES*IDX_W-1:0] cc_activation_indices,
   output logic                   cc_issue,
   output logic                   coord_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   cfg_err,
   output state_t                 dbg_state
`ifdef COORD_SEQ_STALL_COUNT_EN
   ,
   output logic [31:0]            stall_cycles,
   output logic [31:0]            issue_count
`endif
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t                 state;
   logic [CNT_W-1:0]       cpt_q;
   logic [CNT_W-1:0]       nt_q;
   logic [CNT_W-1:0]       chunk_cnt;
   logic [CNT_W-1:0]       tile_cnt;
   logic                   transfer;
   logic                   abort_act;
   logic                   pipe_empty;
   logic [LANES*IDX_W-1:0] w_masked;
   logic [LANES*IDX_W-1:0] a_masked;

   assign w_ready   = (state == ST_RUN) && a_valid;
   assign a_ready   = (state == ST_RUN) && w_valid;
   assign transfer  = (state == ST_RUN) && w_valid && a_valid;
   assign abort_act = abort && (state != ST_IDLE);
   assign dbg_state = state;

   // Lanes beyond the active lane count are forced to zero.
   always_comb begin
      w_masked = '0;
      a_masked = '0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_active(cc_bitwidth, i, LANES)) begin
            w_masked[i*IDX_W +: IDX_W] = w_indices[i*IDX_W +: IDX_W];
            a_masked[i*IDX_W +: IDX_W] = a_indices[i*IDX_W +: IDX_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state                 <= ST_IDLE;
         busy                  <= 1'b0;
         done                  <= 1'b0;
         cfg_err               <= 1'b0;
         cc_clear_n            <= 1'b0;
         cc_issue              <= 1'b0;
         cc_bitwidth           <= '0;
         cc_weight_dim         <= '0;
         cc_activation_dim     <= '0;
         cc_weight_indices     <= '0;
         cc_activation_indices <= '0;
         cpt_q                 <= '0;
         nt_q                  <= '0;
         chunk_cnt             <= '0;
         tile_cnt              <= '0;
      end else begin
         done       <= 1'b0;
         cfg_err    <= 1'b0;
         cc_clear_n <= 1'b1;
         cc_issue   <= 1'b0;
         if (abort_act) begin
            // Drop the job; the pulse on cc_clear_n wipes partial prefix state.
            state      <= ST_IDLE;
            busy       <= 1'b0;
            cc_clear_n <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     cc_bitwidth       <= bitwidth;
                     cc_weight_dim     <= weight_dim;
                     cc_activation_dim <= activation_dim;
                     cpt_q             <= chunks_per_tile;
                     nt_q              <= num_tiles;
                     chunk_cnt         <= '0;
                     tile_cnt          <= '0;
                     if (bitwidth == BW_BAD) begin
                        cfg_err <= 1'b1;
                     end else if (chunks_per_tile == '0 || num_tiles == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b1;
                     end else begin
                        state      <= ST_CLEAR;
                        busy       <= 1'b1;
                        cc_clear_n <= 1'b0;
                     end
                  end
               end
               ST_CLEAR: begin
                  chunk_cnt <= '0;
                  state     <= ST_RUN;
               end
               ST_RUN: begin
                  if (transfer) begin
                     cc_issue              <= 1'b1;
                     cc_weight_indices     <= w_masked;
                     cc_activation_indices <= a_masked;
                     chunk_cnt             <= chunk_cnt + ONE;
                     if (chunk_cnt == cpt_q - ONE) begin
                        state <= ST_DRAIN;
                     end
                  end
               end
               ST_DRAIN: begin
                  // The last issue is still on cc_issue or inside the delay line
                  // until both are clear.
                  if (!cc_issue && pipe_empty) begin
                     tile_cnt <= tile_cnt + ONE;
                     if (tile_cnt == nt_q - ONE) begin
                        state <= ST_DONE;
                     end else begin
                        state      <= ST_CLEAR;
                        cc_clear_n <= 1'b0;
                     end
                  end
               end
               ST_DONE: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   coord_valid_pipe #(
      .LAT(COORD_LAT)
   ) u_valid_pipe (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (abort_act),
      .in_valid (cc_issue),
      .out_valid(coord_valid),
      .empty    (pipe_empty)
   );

`ifdef COORD_SEQ_STALL_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= '0;
         issue_count  <= '0;
      end else if (state == ST_IDLE && start && !abort) begin
         stall_cycles <= '0;
         issue_count  <= '0;
      end else if (state == ST_RUN && !abort) begin
         if (transfer) begin
            issue_count <= issue_count + 32'd1;
         end else begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule
